branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit_pkg.sv | 53 +++++
 rtl/branch_unit_if.sv | 37 +++
 rtl/branch_unit_compare_flags.sv | 22 ++
 rtl/branch_unit.sv | 107 ++++++++++
 tb/tb_branch_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_unit_pkg
//   Shared CPU package for the branch unit: condition-code constants, the
//   branch FSM state encoding, default widths and the condition decoder.
//   No ports; imported by branch_unit_if, compare_flags and branch_unit.
// ----------------------------------------------------------------------------
package branch_unit_pkg;

   // Default geometry
   localparam int DEF_WIDTH        = 6;
   localparam int DEF_FLUSH_CYCLES = 2;
   localparam int DEF_CNT_W        = 8;
   localparam int FLUSH_CNT_W      = 4;

   // Condition codes
   localparam logic [2:0] COND_NOP = 3'b000;
   localparam logic [2:0] COND_BLT = 3'b001;
   localparam logic [2:0] COND_BGT = 3'b010;
   localparam logic [2:0] COND_BEQ = 3'b011;
   localparam logic [2:0] COND_BLE = 3'b100;
   localparam logic [2:0] COND_BGE = 3'b101;
   localparam logic [2:0] COND_BNE = 3'b110;
   localparam logic [2:0] COND_JMP = 3'b111;

   // Branch FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Resolve a condition code against the one-hot compare flags.
   function automatic logic cond_taken(input logic [2:0] c,
                                       input logic lt,
                                       input logic eq,
                                       input logic gt);
      logic t;
      t = 1'b0;
      unique case (c)
         COND_NOP: t = 1'b0;
         COND_BLT: t = lt;
         COND_BGT: t = gt;
         COND_BEQ: t = eq;
         COND_BLE: t = lt | eq;
         COND_BGE: t = gt | eq;
         COND_BNE: t = ~eq;
         COND_JMP: t = 1'b1;
         default:  t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// ----------------------------------------------------------------------------
// branch_unit_if
//   Request/resolve bus of the branch unit.
//   Request side : inValid, inReady, cond, opA, opB, target
//   Resolve side : pc, resolveValid, taken, flush, takenCount
//   master = requester (pipeline front end), slave = branch_unit.
// ----------------------------------------------------------------------------
interface branch_unit_if
   import branch_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   logic             inValid;
   logic             inReady;
   logic [2:0]       cond;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic             resolveValid;
   logic             taken;
   logic             flush;
   logic [CNT_W-1:0] takenCount;

   modport master (
      output inValid, cond, opA, opB, target,
      input  inReady, pc, resolveValid, taken, flush, takenCount
   );

   modport slave (
      input  inValid, cond, opA, opB, target,
      output inReady, pc, resolveValid, taken, flush, takenCount
   );

endinterface

// File: rtl/branch_unit_compare_flags.sv
// ----------------------------------------------------------------------------
// compare_flags
//   Unsigned full-width magnitude compare; exactly one of lt/eq/gt is set.
//   Ports: a, b (WIDTH, unsigned) -> lt, eq, gt.
// ----------------------------------------------------------------------------
module compare_flags
   import branch_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   assign lt = (a <  b);
   assign eq = (a == b);
   assign gt = (a >  b);

endmodule

// File: rtl/branch_unit.sv
// ----------------------------------------------------------------------------
// branch_unit
//   Resolves one conditional branch at a time: accept in IDLE, evaluate the
//   latched operands for one cycle in EVAL, update pc/taken and pulse
//   resolveValid, then hold flush for FLUSH_CYCLES cycles after a taken
//   branch. Also keeps a saturating count of taken branches.
//   Ports: clk, reset (sync, active high), bus (branch_unit_if.slave).
// ----------------------------------------------------------------------------
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   branch_unit_if.slave bus
);

   state_e                 state_q;
   logic [2:0]             cond_q;
   logic [WIDTH-1:0]       a_q;
   logic [WIDTH-1:0]       b_q;
   logic [WIDTH-1:0]       tgt_q;
   logic [WIDTH-1:0]       pc_q;
   logic                   taken_q;
   logic                   rv_q;
   logic                   flush_q;
   logic [FLUSH_CNT_W-1:0] fcnt_q;
   logic [CNT_W-1:0]       tcnt_q;

   logic lt, eq, gt;
   logic tk;

   compare_flags #(.WIDTH(WIDTH)) u_cmp (
      .a  (a_q),
      .b  (b_q),
      .lt (lt),
      .eq (eq),
      .gt (gt)
   );

   assign tk = cond_taken(cond_q, lt, eq, gt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cond_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         tgt_q   <= '0;
         pc_q    <= '0;
         taken_q <= 1'b0;
         rv_q    <= 1'b0;
         flush_q <= 1'b0;
         fcnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         rv_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.inValid) begin
                  cond_q  <= bus.cond;
                  a_q     <= bus.opA;
                  b_q     <= bus.opB;
                  tgt_q   <= bus.target;
                  state_q <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               rv_q    <= 1'b1;
               taken_q <= tk;
               pc_q    <= tk ? tgt_q : pc_q + 1'b1;
               if (tk && tcnt_q != '1)
                  tcnt_q <= tcnt_q + 1'b1;
               // flush rises together with resolveValid; the counter holds
               // the number of flush cycles still to come after this one
               if (tk && FLUSH_CYCLES > 0) begin
                  flush_q <= 1'b1;
                  fcnt_q  <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                  state_q <= ST_FLUSH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (fcnt_q == '0) begin
                  flush_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  fcnt_q <= fcnt_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.inReady      = (state_q == ST_IDLE);
   assign bus.pc           = pc_q;
   assign bus.resolveValid = rv_q;
   assign bus.taken        = taken_q;
   assign bus.flush        = flush_q;
   assign bus.takenCount   = tcnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_unit
//   Directed bench for branch_unit (WIDTH=6, FLUSH_CYCLES=2, CNT_W=8).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_branch_unit;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   branch_unit_if #(.WIDTH(6), .CNT_W(8)) bif ();

   branch_unit #(.WIDTH(6), .FLUSH_CYCLES(2), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bif.inReady !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'd0, bif.inReady}, 32'd1);
   endtask

   // Accept one request; returns at the falling edge of the EVAL cycle.
   task automatic issue(input logic [2:0] c, input logic [5:0] a,
                        input logic [5:0] b, input logic [5:0] t);
      wait_ready();
      bif.cond    = c;
      bif.opA     = a;
      bif.opB     = b;
      bif.target  = t;
      bif.inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif.inValid = 1'b0;
      chk("eval_rv", {31'd0, bif.resolveValid}, 32'd0);
      chk("eval_rdy", {31'd0, bif.inReady}, 32'd0);
   endtask

   logic [7:0] tab [3];
   logic [5:0] ta   [3];
   logic [5:0] tb_  [3];
   logic [5:0] exp_pc;
   logic [5:0] tgt;
   logic       e;
   int         accepts;

   initial begin
      // taken bit per cond code (bit index = cond) for pairs (4,4),(1,2),(2,1)
      tab[0] = 8'b1011_1000; ta[0] = 6'd4; tb_[0] = 6'd4;
      tab[1] = 8'b1101_0010; ta[1] = 6'd1; tb_[1] = 6'd2;
      tab[2] = 8'b1110_0100; ta[2] = 6'd2; tb_[2] = 6'd1;

      reset = 1'b1;
      bif.inValid = 1'b0;
      bif.cond = 3'd0; bif.opA = '0; bif.opB = '0; bif.target = '0;
      repeat (3) @(negedge clk);
      chk("rst_pc",    {26'd0, bif.pc}, 32'd0);
      chk("rst_taken", {31'd0, bif.taken}, 32'd0);
      chk("rst_rv",    {31'd0, bif.resolveValid}, 32'd0);
      chk("rst_flush", {31'd0, bif.flush}, 32'd0);
      chk("rst_cnt",   {24'd0, bif.takenCount}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", {31'd0, bif.inReady}, 32'd1);

      // walk pc to 5 with NOPs
      for (int i = 0; i < 5; i++) begin
         issue(3'b000, 6'd0, 6'd0, 6'd50);
         @(negedge clk);
         chk("nop_rv", {31'd0, bif.resolveValid}, 32'd1);
         chk("nop_pc", {26'd0, bif.pc}, 32'(i + 1));
      end

      // BLT taken 3<7 -> 20
      issue(3'b001, 6'd3, 6'd7, 6'd20);
      @(negedge clk);
      chk("blt_rv",    {31'd0, bif.resolveValid}, 32'd1);
      chk("blt_taken", {31'd0, bif.taken}, 32'd1);
      chk("blt_pc",    {26'd0, bif.pc}, 32'd20);
      chk("blt_flush", {31'd0, bif.flush}, 32'd1);
      chk("blt_cnt",   {24'd0, bif.takenCount}, 32'd1);
      chk("blt_rdy",   {31'd0, bif.inReady}, 32'd0);
      @(negedge clk);
      chk("blt_rv2",    {31'd0, bif.resolveValid}, 32'd0);
      chk("blt_flush2", {31'd0, bif.flush}, 32'd1);
      chk("blt_rdy2",   {31'd0, bif.inReady}, 32'd0);
      @(negedge clk);
      chk("blt_flush3", {31'd0, bif.flush}, 32'd0);
      chk("blt_rdy3",   {31'd0, bif.inReady}, 32'd1);

      // JMP to 63, then BGE 2>=9 not taken -> wraps to 0
      issue(3'b111, 6'd0, 6'd0, 6'd63);
      @(negedge clk);
      chk("jmp63_pc", {26'd0, bif.pc}, 32'd63);
      issue(3'b101, 6'd2, 6'd9, 6'd40);
      @(negedge clk);
      chk("bge_rv",    {31'd0, bif.resolveValid}, 32'd1);
      chk("bge_taken", {31'd0, bif.taken}, 32'd0);
      chk("bge_pc",    {26'd0, bif.pc}, 32'd0);
      chk("bge_flush", {31'd0, bif.flush}, 32'd0);
      chk("bge_rdy",   {31'd0, bif.inReady}, 32'd1);
      chk("bge_cnt",   {24'd0, bif.takenCount}, 32'd2);
      @(negedge clk);
      chk("bge_flush2", {31'd0, bif.flush}, 32'd0);
      chk("bge_rv2",    {31'd0, bif.resolveValid}, 32'd0);

      // full condition table
      exp_pc = 6'd0;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 8; c++) begin
            tgt = 6'(8 * p + c + 8);
            issue(3'(c), ta[p], tb_[p], tgt);
            @(negedge clk);
            e = tab[p][c];
            exp_pc = e ? tgt : exp_pc + 6'd1;
            chk("tab_taken", {31'd0, bif.taken}, {31'd0, e});
            chk("tab_pc",    {26'd0, bif.pc}, {26'd0, exp_pc});
            chk("tab_flush", {31'd0, bif.flush}, {31'd0, e});
         end
      end

      // saturation: 260 JMPs from a clean counter
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 260; i++) begin
         issue(3'b111, 6'd0, 6'd0, 6'(i));
         @(negedge clk);
         chk("sat_rv", {31'd0, bif.resolveValid}, 32'd1);
      end
      chk("sat_cnt", {24'd0, bif.takenCount}, 32'd255);
      chk("sat_pc",  {26'd0, bif.pc}, 32'd3);

      // reset during EVAL: no pulse, no pc update
      issue(3'b111, 6'd0, 6'd0, 6'd44);
      reset = 1'b1;
      @(negedge clk);
      chk("rsteval_rv",  {31'd0, bif.resolveValid}, 32'd0);
      chk("rsteval_pc",  {26'd0, bif.pc}, 32'd0);
      chk("rsteval_cnt", {24'd0, bif.takenCount}, 32'd0);
      reset = 1'b0;

      // reset during FLUSH of a taken BEQ
      issue(3'b011, 6'd9, 6'd9, 6'd30);
      @(negedge clk);
      chk("beq_pc",    {26'd0, bif.pc}, 32'd30);
      chk("beq_flush", {31'd0, bif.flush}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstfl_pc",    {26'd0, bif.pc}, 32'd0);
      chk("rstfl_flush", {31'd0, bif.flush}, 32'd0);
      chk("rstfl_cnt",   {24'd0, bif.takenCount}, 32'd0);
      chk("rstfl_rdy",   {31'd0, bif.inReady}, 32'd1);
      reset = 1'b0;

      // back-to-back NOPs from pc=10
      issue(3'b111, 6'd0, 6'd0, 6'd10);
      @(negedge clk);
      wait_ready();
      bif.cond    = 3'b000;
      bif.inValid = 1'b1;
      accepts     = 0;
      for (int k = 0; k < 7; k++) begin
         chk("b2b_rdy", {31'd0, bif.inReady}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_rv",  {31'd0, bif.resolveValid}, (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_pc",  {26'd0, bif.pc}, 32'(10 + k / 2));
         if (bif.inReady) accepts++;
         @(negedge clk);
      end
      bif.inValid = 1'b0;
      chk("b2b_accepts", 32'(accepts), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
